cdp1802_dma_out: RTL

//   DMA-out responder for the CDP1861 display's DMAO request. At machine-cycle boundaries it steals
//   S2 cycles from the CPU, reads RAM at the R0 pointer, presents each byte as display DataIn with
//   SC=DMA, TPA/TPB strobes and a post-increment of R0. Sits between cdp1802 and cdp1861 in rcastudioii.

---
 rtl/studio2_pkg.sv | 18 +
 rtl/cdp1802_cycle_timer.sv | 41 ++++
 rtl/cdp1802_dma_out.sv | 114 +++++++++++
 3 files changed

// File: rtl/studio2_pkg.sv
// Shared constants for the Studio II CPU/display glue logic.
// State codes, timing-pulse phases and the DMA responder state type.
package studio2_pkg;

   localparam logic [1:0] SC_FETCH = 2'b00;
   localparam logic [1:0] SC_EXEC  = 2'b01;
   localparam logic [1:0] SC_DMA   = 2'b10;
   localparam logic [1:0] SC_INT   = 2'b11;

   localparam int TPA_PHASE = 1;
   localparam int TPB_PHASE = 6;

   typedef enum logic {
      ST_CPU,
      ST_DMA
   } dma_state_e;

endpackage

// File: rtl/cdp1802_cycle_timer.sv
// Machine-cycle phase counter with TPA/TPB strobes.
// Strobes are registered so they cover exactly their phase.
module cdp1802_cycle_timer
   import studio2_pkg::*;
#(
   parameter int CYCLE_CLKS = 8
) (
   input  logic clk,
   input  logic resetq,
   input  logic ce,
   output logic tpa,
   output logic tpb,
   output logic last,
   output logic pre_tpb
);

   localparam int PW = $clog2(CYCLE_CLKS);
   localparam logic [PW-1:0] LAST_PH = PW'(CYCLE_CLKS - 1);
   localparam logic [PW-1:0] TPA_PH  = PW'(TPA_PHASE);
   localparam logic [PW-1:0] TPB_PH  = PW'(TPB_PHASE);

   logic [PW-1:0] phase;
   logic [PW-1:0] phase_nxt;

   assign last      = (phase == LAST_PH);
   assign phase_nxt = last ? '0 : phase + PW'(1);
   assign pre_tpb   = (phase_nxt == TPB_PH);

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         phase <= '0;
         tpa   <= 1'b0;
         tpb   <= 1'b0;
      end else if (ce) begin
         phase <= phase_nxt;
         tpa   <= (phase_nxt == TPA_PH);
         tpb   <= (phase_nxt == TPB_PH);
      end
   end

endmodule

// File: rtl/cdp1802_dma_out.sv
// DMA-out responder: steals machine cycles to fetch display bytes at R0.
// R0 post-increments at the end of each DMA cycle.
module cdp1802_dma_out
   import studio2_pkg::*;
#(
   parameter int CYCLE_CLKS = 8,
   parameter int MAX_BURST  = 8
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        ce,
   input  logic [1:0]  cpu_sc,
   input  logic        dma_out_req,
   input  logic        dma_allow,
   input  logic        r0_wr,
   input  logic [15:0] r0_din,
   output logic [15:0] r0_q,
   output logic        ram_rd,
   output logic [15:0] ram_a,
   input  logic [7:0]  ram_q,
   output logic        tpa,
   output logic        tpb,
   output logic [1:0]  sc,
   output logic        dma_cycle,
   output logic [7:0]  dma_data,
   output logic        dma_data_valid,
   output logic        overrun,
   input  logic        overrun_clr
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   dma_state_e    state;
   logic          last;
   logic          pre_tpb;
   logic          boundary;
   logic          grant;
   logic          inc;
   logic          fetch_pend;
   logic          ovr_set;
   logic [15:0]   r0_nxt;
   logic [BW-1:0] burst;

   cdp1802_cycle_timer #(
      .CYCLE_CLKS(CYCLE_CLKS)
   ) u_timer (
      .clk    (clk),
      .resetq (resetq),
      .ce     (ce),
      .tpa    (tpa),
      .tpb    (tpb),
      .last   (last),
      .pre_tpb(pre_tpb)
   );

   assign dma_cycle = (state == ST_DMA);
   assign boundary  = ce && last;
   assign grant     = boundary && dma_out_req && dma_allow;
   assign inc       = boundary && dma_cycle;
   assign ovr_set   = grant && (burst == BURST_MAX);

   // A same-clock load beats the end-of-cycle increment.
   always_comb begin
      r0_nxt = r0_q;
      if (r0_wr)
         r0_nxt = r0_din;
      else if (inc)
         r0_nxt = r0_q + 16'd1;
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state          <= ST_CPU;
         r0_q           <= 16'h0000;
         ram_a          <= 16'h0000;
         ram_rd         <= 1'b0;
         fetch_pend     <= 1'b0;
         dma_data       <= 8'h00;
         dma_data_valid <= 1'b0;
         sc             <= SC_FETCH;
         burst          <= '0;
         overrun        <= 1'b0;
      end else begin
         r0_q           <= r0_nxt;
         ram_rd         <= grant;
         fetch_pend     <= ram_rd;
         dma_data_valid <= ce && pre_tpb && dma_cycle;
         if (fetch_pend)
            dma_data <= ram_q;
         if (ce) begin
            if (boundary)
               sc <= grant ? SC_DMA : cpu_sc;
            else
               sc <= dma_cycle ? SC_DMA : cpu_sc;
         end
         if (boundary) begin
            state <= grant ? ST_DMA : ST_CPU;
            if (grant) begin
               ram_a <= r0_nxt;
               if (burst != BURST_MAX)
                  burst <= burst + BW'(1);
            end else begin
               burst <= '0;
            end
         end
         if (ovr_set)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;
      end
   end

endmodule
